// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
// Both the top level and the grant sub-module import this package.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0]  FETCH_BE     = 4'hF;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  function automatic state_t bus_state(input owner_t owner);
    return (owner == OWN_D) ? BUS_D : BUS_I;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb2_rr.sv
// Combinational two-requester grant: fixed data priority or alternation on ties.
// The caller decides when to sample the grant and when to update last_grant.
module arb2_rr
  import mem_bus_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output logic   gnt_valid,
  output owner_t gnt
);

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt       = OWN_I;
    if (i_req && d_req) begin
      if (PRIORITY_MODE == 1) begin
        gnt = OWN_D;
      end else begin
        gnt = (last_grant == OWN_D) ? OWN_I : OWN_D;
      end
    end else if (d_req) begin
      gnt = OWN_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-style memory bus between the CPU fetch port and the data port.
// One command in flight at a time, registered bus fields, waitrequest timeout abort.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshake: a port raises req with its fields stable and holds them until its
  // one-cycle ack; req is only sampled in IDLE, so the ack cycle never re-grants.
  state_t        state_q, state_d;
  owner_t        last_grant_q, last_grant_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          err_q, err_d;

  owner_t gnt;
  logic   gnt_valid;

  arb2_rr #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_D;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tmo_d        = tmo_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = bus_state(gnt);
          last_grant_d = gnt;
          tmo_d        = '0;
          if (gnt == OWN_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_byteenable;
          end else begin
            we_d   = 1'b0;
            addr_d = i_addr;
            be_d   = FETCH_BE;
          end
        end
      end
      BUS_I, BUS_D: begin
        if (!waitrequest) begin
          state_d = RESP;
          tmo_d   = '0;
          if (!we_q) begin
            if (state_q == BUS_I) i_rdata_d = readdata;
            else                  d_rdata_d = readdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Hung slave: abandon the command and report it with the ack.
          state_d = RESP;
          tmo_d   = '0;
          err_d   = 1'b1;
          if (state_q == BUS_I) i_rdata_d = '0;
          else                  d_rdata_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read  = 1'b0;
    write = 1'b0;
    i_ack = 1'b0;
    d_ack = 1'b0;
    case (state_q)
      BUS_I: read = 1'b1;
      BUS_D: begin
        read  = ~we_q;
        write = we_q;
      end
      RESP: begin
        i_ack = (last_grant_q == OWN_I);
        d_ack = (last_grant_q == OWN_D);
      end
      default: ;
    endcase
  end

  assign err        = err_q & (state_q == RESP);
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random transactions, checked
// against a transaction-level model (grant order, latency, memory contents).
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_byteenable;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic        i_ack, d_ack, err, read, write;
  logic [3:0]  byteenable;

  logic        p_i_req, p_d_req, p_d_we, p_wait;
  logic [31:0] p_i_addr, p_d_addr, p_d_wdata, p_readdata;
  logic [3:0]  p_d_be;
  logic [31:0] p_i_rdata, p_d_rdata, p_address, p_writedata;
  logic        p_i_ack, p_d_ack, p_err, p_read, p_write;
  logic [3:0]  p_byteenable;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  bit          m_last_d;
  logic [31:0] m_d_rdata;
  int          stall_left;
  bit          strobe_prev;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(4)) u_pri (
    .clk(clk), .reset(reset),
    .i_req(p_i_req), .i_addr(p_i_addr), .i_rdata(p_i_rdata), .i_ack(p_i_ack),
    .d_req(p_d_req), .d_we(p_d_we), .d_addr(p_d_addr), .d_wdata(p_d_wdata),
    .d_byteenable(p_d_be), .d_rdata(p_d_rdata), .d_ack(p_d_ack), .err(p_err),
    .address(p_address), .read(p_read), .write(p_write), .writedata(p_writedata),
    .byteenable(p_byteenable), .waitrequest(p_wait), .readdata(p_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_checks();
    chk("exclusive", 32'({read & write, i_ack & d_ack, err & ~(i_ack | d_ack)}), 32'd0);
  endtask

  // Bus slave: stalls a new command for plan_stall edges (>=4 means never answers).
  task automatic bus_respond(input int plan_stall, output bit onset);
    bit strobe;
    strobe = read | write;
    onset  = strobe & ~strobe_prev;
    if (onset) stall_left = (plan_stall >= 4) ? 1000 : plan_stall;
    if (strobe) begin
      if (stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
      end else begin
        waitrequest = 1'b0;
        readdata    = bus_rd(address);
        if (write) bus_mem[address] = merge(bus_rd(address), writedata, byteenable);
      end
    end else begin
      waitrequest = 1'($urandom_range(0, 1));
      readdata    = $urandom;
    end
    strobe_prev = strobe;
  endtask

  task automatic run_txn(input bit use_i, input bit use_d, input int st_i, input int st_d);
    bit first_d, i_pend, d_pend, onset, cur_d;
    int eff_i, eff_d, exp_i_cyc, exp_d_cyc, n_onset, strobe_cnt;
    logic [31:0] exp_i_rd, exp_d_rd;
    first_d = (use_i && use_d) ? ~m_last_d : use_d;
    eff_i = (st_i >= 4) ? 3 : st_i;
    eff_d = (st_d >= 4) ? 3 : st_d;
    if (first_d) begin
      exp_d_cyc = 2 + eff_d;
      exp_i_cyc = exp_d_cyc + 3 + eff_i;
    end else begin
      exp_i_cyc = 2 + eff_i;
      exp_d_cyc = exp_i_cyc + 3 + eff_d;
    end
    m_last_d = (use_i && use_d) ? ~first_d : use_d;
    exp_i_rd = (st_i >= 4) ? 32'd0 : ref_rd(i_addr);
    if (d_we) exp_d_rd = m_d_rdata;
    else      exp_d_rd = (st_d >= 4) ? 32'd0 : ref_rd(d_addr);
    if (use_d && d_we) ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_byteenable);

    i_req = use_i; d_req = use_d; i_pend = use_i; d_pend = use_d;
    n_onset = 0; cur_d = 1'b0; strobe_cnt = 0;
    for (int cyc = 1; cyc <= 40 && (i_pend || d_pend); cyc++) begin
      tick();
      cycle_checks();
      bus_respond((n_onset == 0) ? (first_d ? st_d : st_i) : (first_d ? st_i : st_d), onset);
      if (onset) begin
        n_onset++;
        cur_d = (n_onset == 1) ? first_d : ~first_d;
        strobe_cnt = 1;
        if (cur_d) begin
          chk("d_bus_addr", address, d_addr);
          chk("d_bus_strobe", 32'({write, read}), d_we ? 32'd2 : 32'd1);
          chk("d_bus_be", 32'(byteenable), 32'(d_byteenable));
          if (d_we) chk("d_bus_wdata", writedata, d_wdata);
        end else begin
          chk("i_bus_addr", address, i_addr);
          chk("i_bus_strobe", 32'({write, read}), 32'd1);
          chk("i_bus_be", 32'(byteenable), 32'(FETCH_BE));
        end
      end else if (read | write) begin
        strobe_cnt++;
        chk("bus_addr_hold", address, cur_d ? d_addr : i_addr);
      end
      if (i_ack) begin
        chk("i_ack_expected", 32'(i_pend), 32'd1);
        chk("i_ack_cycle", 32'(cyc), 32'(exp_i_cyc));
        chk("i_strobe_len", 32'(strobe_cnt), 32'(1 + eff_i));
        chk("i_rdata", i_rdata, exp_i_rd);
        chk("i_err", 32'(err), 32'(st_i >= 4));
        i_req = 1'b0; i_pend = 1'b0;
      end
      if (d_ack) begin
        chk("d_ack_expected", 32'(d_pend), 32'd1);
        chk("d_ack_cycle", 32'(cyc), 32'(exp_d_cyc));
        chk("d_strobe_len", 32'(strobe_cnt), 32'(1 + eff_d));
        chk("d_rdata", d_rdata, exp_d_rd);
        chk("d_err", 32'(err), 32'(st_d >= 4));
        d_req = 1'b0; d_pend = 1'b0;
      end
    end
    chk("ack_wait", 32'({i_pend, d_pend}), 32'd0);
    if (use_d) m_d_rdata = exp_d_rd;
    i_req = 1'b0; d_req = 1'b0;
    tick();
    cycle_checks();
    bus_respond(0, onset);
    chk("post_idle", 32'({read, write, i_ack, d_ack}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit onset;
    int d_at, i_at, last_ack, n;
    logic [31:0] p_rd;
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; waitrequest = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; readdata = 0; d_byteenable = 0;
    p_i_req = 0; p_d_req = 0; p_d_we = 0; p_wait = 0;
    p_i_addr = 0; p_d_addr = 0; p_d_wdata = 0; p_readdata = 0; p_d_be = 0;
    strobe_prev = 0; stall_left = 0; m_last_d = 1; m_d_rdata = 0;
    tick(); tick();
    chk("rst_strobes_acks", 32'({read, write, i_ack, d_ack, err}), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;

    // Tie right after reset: round-robin serves fetch first.
    i_addr = RESET_VECTOR; d_addr = 32'h10; d_we = 0; d_byteenable = 4'hF;
    run_txn(1, 1, 0, 0);

    // Priority mode instance: data wins the same tie.
    p_i_addr = RESET_VECTOR; p_d_addr = 32'h10; p_d_be = 4'hF;
    p_readdata = 32'hCAFE0010; p_i_req = 1; p_d_req = 1;
    d_at = -1; i_at = -1; p_rd = 32'd0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) chk("pri_first_addr", p_address, 32'h10);
      if (p_d_ack) begin d_at = cyc; p_rd = p_d_rdata; p_d_req = 0; end
      if (p_i_ack) begin i_at = cyc; p_i_req = 0; end
    end
    chk("pri_d_ack_cycle", 32'(d_at), 32'd2);
    chk("pri_i_ack_cycle", 32'(i_at), 32'd5);
    chk("pri_d_rdata", p_rd, 32'hCAFE0010);

    // Boot-ROM fetch with known word.
    bus_mem[RESET_VECTOR] = 32'h3C08BFC0;
    ref_mem[RESET_VECTOR] = 32'h3C08BFC0;
    i_addr = RESET_VECTOR;
    run_txn(1, 0, 0, 0);

    // Stalled partial write, then read it back.
    d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_byteenable = 4'b0011; d_we = 1;
    run_txn(0, 1, 0, 3);
    d_we = 0; d_byteenable = 4'hF;
    run_txn(0, 1, 0, 0);

    // Timeouts on fetch and data read, each followed by a normal access.
    i_addr = RESET_VECTOR + 32'h8;
    run_txn(1, 0, 4, 0);
    run_txn(1, 0, 0, 0);
    d_addr = 32'h24;
    run_txn(0, 1, 0, 4);
    run_txn(0, 1, 0, 1);

    // Asynchronous reset in the middle of a stalled data read.
    d_addr = 32'h40; d_we = 0; d_req = 1;
    tick(); bus_respond(1000, onset);
    tick(); bus_respond(1000, onset);
    chk("pre_rst_read", 32'(read), 32'd1);
    #3 reset = 1'b1;
    #1 chk("rst_async_outputs", 32'({read, write, i_ack, d_ack, err}), 32'd0);
    d_req = 0; waitrequest = 0;
    @(posedge clk); #1 reset = 1'b0;
    strobe_prev = 0; m_last_d = 1; m_d_rdata = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_ack", 32'({i_ack, d_ack, read, write}), 32'd0);
    end
    chk("rst_d_rdata_clear", d_rdata, 32'd0);
    i_addr = RESET_VECTOR + 32'h4; d_addr = 32'h20;
    run_txn(1, 1, 0, 0);

    // Back-to-back fetches with i_req held.
    i_addr = RESET_VECTOR + 32'h100; i_req = 1; last_ack = 0; n = 0;
    for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
      tick();
      cycle_checks();
      bus_respond(0, onset);
      if (onset) chk("b2b_addr", address, i_addr);
      chk("b2b_no_d_ack", 32'(d_ack), 32'd0);
      if (i_ack) begin
        chk("b2b_rdata", i_rdata, ref_rd(i_addr));
        chk("b2b_spacing", 32'(cyc - last_ack), (n == 0) ? 32'd2 : 32'd3);
        last_ack = cyc; n++;
        i_addr = i_addr + 32'd4;
      end
    end
    chk("b2b_count", 32'(n), 32'd4);
    i_req = 0; m_last_d = 0;
    tick(); cycle_checks(); bus_respond(0, onset);

    // Random mix of single and contended transactions.
    for (int k = 0; k < 40; k++) begin
      int kind, s_i, s_d;
      kind = $urandom_range(0, 2);
      i_addr = RESET_VECTOR + 32'(4 * $urandom_range(0, 63));
      d_addr = 32'(4 * $urandom_range(0, 15));
      d_we = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      d_byteenable = 4'($urandom_range(1, 15));
      s_i = $urandom_range(0, 4);
      s_d = $urandom_range(0, 4);
      if (d_we && s_d == 4) s_d = 2;
      run_txn(kind != 1, kind != 0, s_i, s_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
